gate_pattern_tester: RTL and testbench

//   Parametrised successor of the fixed 3-input checker. Exhaustively drives all 2**NUM_INPUTS

---
 rtl/ic_tester_pkg.sv | 69 ++++++
 rtl/gate_golden_model.sv | 30 +++
 rtl/gate_pattern_tester.sv | 200 ++++++++++++++++++++
 tb/tb_gate_pattern_tester.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_tester_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ic_tester_pkg
//  Description : Shared definitions for the logic-IC pattern tester: gate-type
//                encodings, the controller state enum, and the golden
//                reference function used to predict each gate's output.
//  Contents    : GATE_* codes (3-bit), state_e, sel_is_legal(), golden()
//  Revision    : 1.0 - initial release
// ============================================================================
package ic_tester_pkg;

    // Gate-type encodings presented on gate_sel_i. Codes 6 and 7 are unused
    // and are reported as an illegal selection.
    localparam logic [2:0] GATE_AND  = 3'd0;
    localparam logic [2:0] GATE_OR   = 3'd1;
    localparam logic [2:0] GATE_NAND = 3'd2;
    localparam logic [2:0] GATE_NOR  = 3'd3;
    localparam logic [2:0] GATE_XOR  = 3'd4;
    localparam logic [2:0] GATE_XNOR = 3'd5;

    // Widest pattern the golden function understands.
    localparam int MAX_INPUTS = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EVAL   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // A selection is usable only if it names one of the six gate types.
    // There is no dedicated inverter code: with a single input, NAND/NOR/XNOR
    // all collapse to an inverter, so a one-input IC is tested with one of those.
    function automatic logic sel_is_legal(input logic [2:0] sel);
        return (sel <= GATE_XNOR);
    endfunction

    // Expected output of one gate of type `sel` for input pattern `pat`, where
    // only the low `n` bits of `pat` are real gate inputs. XOR is odd parity.
    function automatic logic golden(input logic [2:0]            sel,
                                    input logic [MAX_INPUTS-1:0] pat,
                                    input int                    n);
        logic all_one;
        logic any_one;
        logic parity;
        all_one = 1'b1;
        any_one = 1'b0;
        parity  = 1'b0;
        for (int i = 0; i < MAX_INPUTS; i++) begin
            if (i < n) begin
                all_one = all_one & pat[i];
                any_one = any_one | pat[i];
                parity  = parity ^ pat[i];
            end
        end
        case (sel)
            GATE_AND:  return all_one;
            GATE_OR:   return any_one;
            GATE_NAND: return ~all_one;
            GATE_NOR:  return ~any_one;
            GATE_XOR:  return parity;
            GATE_XNOR: return ~parity;
            default:   return 1'b0;
        endcase
    endfunction

endpackage : ic_tester_pkg
`default_nettype wire

// File: rtl/gate_golden_model.sv
`default_nettype none
// ============================================================================
//  Module      : gate_golden_model
//  Description : Combinational reference for one gate of the selected type.
//                Every gate in the socket sees the same pattern, so a single
//                instance serves all of them.
//  Ports       : sel_i  [2:0]            gate type (ic_tester_pkg encoding)
//                pat_i  [NUM_INPUTS-1:0] current input pattern
//                exp_o                   expected gate output
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_golden_model
    import ic_tester_pkg::*;
#(
    parameter int NUM_INPUTS = 3
) (
    input  logic [2:0]            sel_i,
    input  logic [NUM_INPUTS-1:0] pat_i,
    output logic                  exp_o
);

    // Zero-extend to the width the package function works on; the function
    // ignores bits at and above NUM_INPUTS.
    logic [MAX_INPUTS-1:0] pat_ext;

    assign pat_ext = MAX_INPUTS'(pat_i);
    assign exp_o   = golden(sel_i, pat_ext, NUM_INPUTS);

endmodule : gate_golden_model
`default_nettype wire

// File: rtl/gate_pattern_tester.sv
`default_nettype none
// ============================================================================
//  Module      : gate_pattern_tester
//  Description : Exhaustive functional tester for NUM_GATES identical gates of
//                a logic IC. Steps through every input pattern, holds each for
//                DWELL_CYCLES clocks, samples the synchronised socket outputs
//                and compares them with the golden model for the latched type.
//  Ports       : clk, rst_n          clock, async active-low reset
//                start_i             level, begins a run from IDLE/DONE
//                gate_sel_i [2:0]    gate type, latched at run start
//                loop_en_i           auto-restart after each DONE
//                dut_out_i  [G-1:0]  socket outputs (asynchronous)
//                stim_o     [G*N-1:0] socket drive, gate g = [g*N +: N]
//                busy_o, done_o      run in progress / one-cycle result strobe
//                pass_vec_o, fail_vec_o [G-1:0] per-gate verdict
//                pass_all_o, fail_any_o, bad_sel_o, first_fail_o [N-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_pattern_tester
    import ic_tester_pkg::*;
#(
    parameter int NUM_INPUTS   = 3,
    parameter int NUM_GATES    = 3,
    parameter int DWELL_CYCLES = 50000000,
    parameter int CNT_W        = 26
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_i,
    input  logic [2:0]                      gate_sel_i,
    input  logic                            loop_en_i,
    input  logic [NUM_GATES-1:0]            dut_out_i,
    output logic [NUM_GATES*NUM_INPUTS-1:0] stim_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [NUM_GATES-1:0]            pass_vec_o,
    output logic [NUM_GATES-1:0]            fail_vec_o,
    output logic                            pass_all_o,
    output logic                            fail_any_o,
    output logic                            bad_sel_o,
    output logic [NUM_INPUTS-1:0]           first_fail_o
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    // ------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------
    state_e                            state_q;
    logic [2:0]                        sel_q;
    logic [NUM_INPUTS-1:0]             pat_q;
    logic [CNT_W-1:0]                  cnt_q;
    logic [NUM_GATES-1:0]              mis_q;
    logic [NUM_INPUTS-1:0]             first_fail_q;
    logic                              bad_sel_q;
    logic [NUM_GATES*NUM_INPUTS-1:0]   stim_q;
    logic                              busy_q;
    logic                              done_q;
    logic [NUM_GATES-1:0]              pass_vec_q;
    logic [NUM_GATES-1:0]              fail_vec_q;
    logic                              pass_all_q;
    logic                              fail_any_q;
    logic [NUM_GATES-1:0]              sync1_q;
    logic [NUM_GATES-1:0]              sync2_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                              exp_bit;
    logic [NUM_GATES-1:0]              mis_d;
    logic [NUM_INPUTS-1:0]             pat_d;
    logic                              launch;

    gate_golden_model #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_golden (
        .sel_i (sel_q),
        .pat_i (pat_q),
        .exp_o (exp_bit)
    );

    // Sticky mismatch: once a gate has disagreed it stays failed for the run.
    assign mis_d  = mis_q | (sync2_q ^ {NUM_GATES{exp_bit}});
    assign pat_d  = pat_q + NUM_INPUTS'(1);
    // From DONE the loop enable restarts on its own; from IDLE only start does.
    assign launch = start_i | (loop_en_i & (state_q == ST_DONE));

    // ------------------------------------------------------------------
    // Controller, synchroniser and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            pat_q        <= '0;
            cnt_q        <= '0;
            mis_q        <= '0;
            first_fail_q <= '0;
            bad_sel_q    <= 1'b0;
            stim_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_vec_q   <= '0;
            fail_vec_q   <= '0;
            pass_all_q   <= 1'b0;
            fail_any_q   <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
        end else begin
            sync1_q <= dut_out_i;
            sync2_q <= sync1_q;
            done_q  <= 1'b0;

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        sel_q        <= gate_sel_i;
                        pat_q        <= '0;
                        cnt_q        <= '0;
                        mis_q        <= '0;
                        first_fail_q <= '0;
                        busy_q       <= 1'b1;
                        // Pattern 0 replicated is all zeros, so stim needs
                        // no update when entering DRIVE.
                        stim_q       <= '0;
                        if (sel_is_legal(gate_sel_i)) begin
                            bad_sel_q <= 1'b0;
                            state_q   <= ST_DRIVE;
                        end else begin
                            // Nothing meaningful to test: report at once.
                            bad_sel_q <= 1'b1;
                            state_q   <= ST_EVAL;
                        end
                    end
                end

                ST_DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_SAMPLE: begin
                    mis_q <= mis_d;
                    if ((mis_q == '0) && (mis_d != '0)) begin
                        first_fail_q <= pat_q;
                    end
                    if (pat_q == '1) begin
                        // Last pattern: leave pat_q alone rather than wrap.
                        stim_q  <= '0;
                        state_q <= ST_EVAL;
                    end else begin
                        pat_q   <= pat_d;
                        cnt_q   <= '0;
                        stim_q  <= {NUM_GATES{pat_d}};
                        state_q <= ST_DRIVE;
                    end
                end

                ST_EVAL: begin
                    // mis_q already includes the final sample here.
                    if (bad_sel_q) begin
                        pass_vec_q <= '0;
                        fail_vec_q <= '1;
                    end else begin
                        pass_vec_q <= ~mis_q;
                        fail_vec_q <= mis_q;
                    end
                    pass_all_q <= ~(|mis_q) & ~bad_sel_q;
                    fail_any_q <= (|mis_q) | bad_sel_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    stim_q     <= '0;
                    state_q    <= ST_DONE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign stim_o       = stim_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_vec_o   = pass_vec_q;
    assign fail_vec_o   = fail_vec_q;
    assign pass_all_o   = pass_all_q;
    assign fail_any_o   = fail_any_q;
    assign bad_sel_o    = bad_sel_q;
    assign first_fail_o = first_fail_q;

endmodule : gate_pattern_tester
`default_nettype wire

// File: tb/tb_gate_pattern_tester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_pattern_tester
//  Description : Self-checking bench for gate_pattern_tester. A socket model
//                of ideal gates (with optional stuck-at-0 outputs) feeds the
//                DUT; a table of directed runs plus hand-written sequences
//                for reset abort, looping and a 2-input/4-gate build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_pattern_tester;
    import ic_tester_pkg::*;

    localparam int NI  = 3;
    localparam int NG  = 3;
    localparam int NI2 = 2;
    localparam int NG2 = 4;
    localparam int D   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- instance 1: 3 inputs x 3 gates ----------------
    logic              start, loop_en;
    logic [2:0]        gate_sel;
    logic [NG-1:0]     dut_out;
    logic [NG*NI-1:0]  stim;
    logic              busy, done, pass_all, fail_any, bad_sel;
    logic [NG-1:0]     pass_vec, fail_vec;
    logic [NI-1:0]     first_fail;
    logic [2:0]        ic_type;
    logic [NG-1:0]     stuck0;

    // ---------------- instance 2: 2 inputs x 4 gates (NOR socket) -----
    logic              start2;
    logic [NG2-1:0]    dut_out2;
    logic [NG2*NI2-1:0] stim2;
    logic              busy2, done2, pass_all2, fail_any2, bad_sel2;
    logic [NG2-1:0]    pass_vec2, fail_vec2;
    logic [NI2-1:0]    first_fail2;

    gate_pattern_tester #(.NUM_INPUTS(NI), .NUM_GATES(NG), .DWELL_CYCLES(D), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .gate_sel_i(gate_sel),
        .loop_en_i(loop_en), .dut_out_i(dut_out), .stim_o(stim), .busy_o(busy),
        .done_o(done), .pass_vec_o(pass_vec), .fail_vec_o(fail_vec),
        .pass_all_o(pass_all), .fail_any_o(fail_any), .bad_sel_o(bad_sel),
        .first_fail_o(first_fail)
    );

    gate_pattern_tester #(.NUM_INPUTS(NI2), .NUM_GATES(NG2), .DWELL_CYCLES(D), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .gate_sel_i(GATE_NOR),
        .loop_en_i(1'b0), .dut_out_i(dut_out2), .stim_o(stim2), .busy_o(busy2),
        .done_o(done2), .pass_vec_o(pass_vec2), .fail_vec_o(fail_vec2),
        .pass_all_o(pass_all2), .fail_any_o(fail_any2), .bad_sel_o(bad_sel2),
        .first_fail_o(first_fail2)
    );

    // Ideal 3-input gate written with reduction operators.
    function automatic logic ref_gate(input logic [2:0] t, input logic [2:0] b);
        case (t)
            3'd0:    return &b;
            3'd1:    return |b;
            3'd2:    return ~&b;
            3'd3:    return ~|b;
            3'd4:    return ^b;
            3'd5:    return ~^b;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        dut_out = '0;
        for (int g = 0; g < NG; g++)
            dut_out[g] = stuck0[g] ? 1'b0 : ref_gate(ic_type, stim[g*NI +: NI]);
    end

    always_comb begin
        dut_out2 = '0;
        for (int g = 0; g < NG2; g++)
            dut_out2[g] = ~|stim2[g*NI2 +: NI2];
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] sel;
        logic [2:0] ic;
        logic [2:0] stuck;
        logic [2:0] pv;
        logic [2:0] fv;
        logic       pa;
        logic       fa;
        logic       bs;
        logic [2:0] ff;
        int         lat;
    } vec_t;

    vec_t tbl[9];

    // One complete run. Latency is the number of rising edges from the one
    // that samples start up to and including the one that raises done.
    task automatic run_one(input int idx, input vec_t v);
        int  n;
        logic got, stim_seen;
        logic [2:0] pv_hold;
        gate_sel = v.sel; ic_type = v.ic; stuck0 = v.stuck;
        start = 1'b1;
        n = 0; got = 1'b0; stim_seen = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                start = 1'b0;
                chk($sformatf("v%0d_busy_after_start", idx), busy, 1'b1);
            end
            if (stim != '0) stim_seen = 1'b1;
            if (done) got = 1'b1;
        end
        chk($sformatf("v%0d_done_seen", idx), got, 1'b1);
        chk($sformatf("v%0d_latency", idx), n, v.lat);
        chk($sformatf("v%0d_pass_vec", idx), pass_vec, v.pv);
        chk($sformatf("v%0d_fail_vec", idx), fail_vec, v.fv);
        chk($sformatf("v%0d_pass_all", idx), pass_all, v.pa);
        chk($sformatf("v%0d_fail_any", idx), fail_any, v.fa);
        chk($sformatf("v%0d_bad_sel", idx), bad_sel, v.bs);
        chk($sformatf("v%0d_first_fail", idx), first_fail, v.ff);
        chk($sformatf("v%0d_busy_at_done", idx), busy, 1'b0);
        chk($sformatf("v%0d_stim_activity", idx), stim_seen, !v.bs);
        pv_hold = pass_vec;
        @(posedge clk); #1;
        chk($sformatf("v%0d_done_one_cycle", idx), done, 1'b0);
        chk($sformatf("v%0d_result_held", idx), pass_vec, pv_hold);
        chk($sformatf("v%0d_stim_idle", idx), stim, '0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stim"}, stim, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_pass_vec"}, pass_vec, '0);
        chk({tag, "_fail_vec"}, fail_vec, '0);
        chk({tag, "_pass_all"}, pass_all, 1'b0);
        chk({tag, "_fail_any"}, fail_any, 1'b0);
        chk({tag, "_bad_sel"}, bad_sel, 1'b0);
        chk({tag, "_first_fail"}, first_fail, '0);
    endtask

    initial begin
        int n, ndone, t1, t2;
        logic run1_pa, hit;
        logic [2:0] run2_fv, run2_ff;
        logic [7:0] prev2;
        logic [7:0] seq2[$];

        //          sel        ic         stuck   pv      fv      pa fa bs ff    lat
        tbl[0] = '{GATE_NAND, GATE_NAND, 3'b000, 3'b111, 3'b000, 1, 0, 0, 3'd0, 42};
        tbl[1] = '{GATE_XOR,  GATE_XOR,  3'b010, 3'b101, 3'b010, 0, 1, 0, 3'd1, 42};
        tbl[2] = '{GATE_AND,  GATE_AND,  3'b000, 3'b111, 3'b000, 1, 0, 0, 3'd0, 42};
        tbl[3] = '{GATE_OR,   GATE_AND,  3'b000, 3'b000, 3'b111, 0, 1, 0, 3'd1, 42};
        tbl[4] = '{GATE_NOR,  GATE_NOR,  3'b100, 3'b011, 3'b100, 0, 1, 0, 3'd0, 42};
        tbl[5] = '{GATE_AND,  GATE_AND,  3'b001, 3'b110, 3'b001, 0, 1, 0, 3'd7, 42};
        tbl[6] = '{3'd7,      GATE_AND,  3'b000, 3'b000, 3'b111, 0, 1, 1, 3'd0, 2};
        tbl[7] = '{3'd6,      GATE_AND,  3'b000, 3'b000, 3'b111, 0, 1, 1, 3'd0, 2};
        tbl[8] = '{GATE_XNOR, GATE_XNOR, 3'b000, 3'b111, 3'b000, 1, 0, 0, 3'd0, 42};

        start = 1'b0; loop_en = 1'b0; gate_sel = GATE_AND;
        ic_type = GATE_AND; stuck0 = '0; start2 = 1'b0;

        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- table-driven runs ----------------
        for (int i = 0; i < 9; i++) run_one(i, tbl[i]);

        // ---------------- reset during pattern 5 ----------------
        gate_sel = GATE_NAND; ic_type = GATE_NAND; stuck0 = '0;
        start = 1'b1;
        n = 0; hit = 1'b0;
        while (!hit && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 1)  start = 1'b0;
            if (n == 12) start = 1'b1;   // start while busy must be ignored
            if (n == 13) start = 1'b0;
            if (stim == {3{3'd5}}) hit = 1'b1;
        end
        chk("abort_pattern5_reached", hit, 1'b1);
        chk("abort_pattern5_timing", n, 26);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_one(100, tbl[0]);

        // ---------------- loop mode ----------------
        gate_sel = GATE_AND; ic_type = GATE_AND; stuck0 = '0;
        loop_en = 1'b1; start = 1'b1;
        n = 0; ndone = 0; t1 = 0; t2 = 0;
        run1_pa = 1'b0; run2_fv = '0; run2_ff = '0;
        while (n < 130) begin
            @(posedge clk); #1;
            n++;
            if (n == 1)  start = 1'b0;
            if (n == 20) gate_sel = GATE_OR;   // must not affect the current run
            if (done) begin
                ndone++;
                if (ndone == 1) begin t1 = n; run1_pa = pass_all; end
                if (ndone == 2) begin t2 = n; run2_fv = fail_vec; run2_ff = first_fail;
                                      loop_en = 1'b0; end
            end
        end
        chk("loop_first_done", t1, 42);
        chk("loop_period", t2 - t1, 42);
        chk("loop_run1_pass_all", run1_pa, 1'b1);
        chk("loop_run2_fail_vec", run2_fv, 3'b111);
        chk("loop_run2_first_fail", run2_ff, 3'd1);
        chk("loop_stops", ndone, 2);
        chk("loop_idle_busy", busy, 1'b0);

        // ---------------- 2-input / 4-gate NOR build ----------------
        start2 = 1'b1;
        n = 0; hit = 1'b0; prev2 = '0;
        while (!hit && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) start2 = 1'b0;
            if (stim2 != prev2) begin seq2.push_back(stim2); prev2 = stim2; end
            if (done2) hit = 1'b1;
        end
        chk("n2_done_seen", hit, 1'b1);
        chk("n2_latency", n, 22);
        chk("n2_stim_changes", seq2.size(), 4);
        if (seq2.size() == 4) begin
            chk("n2_stim_pat1", seq2[0], 8'h55);
            chk("n2_stim_pat2", seq2[1], 8'hAA);
            chk("n2_stim_pat3", seq2[2], 8'hFF);
            chk("n2_stim_off",  seq2[3], 8'h00);
        end
        chk("n2_pass_vec", pass_vec2, 4'b1111);
        chk("n2_fail_vec", fail_vec2, 4'b0000);
        chk("n2_pass_all", pass_all2, 1'b1);
        chk("n2_fail_any", fail_any2, 1'b0);
        chk("n2_bad_sel", bad_sel2, 1'b0);
        chk("n2_first_fail", first_fail2, 2'd0);
        chk("n2_busy", busy2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_gate_pattern_tester
`default_nettype wire
